datapath_gen: RTL and testbench

Parametrised next-generation datapath for the lab CPU: register file, A/B operand registers, shifter, ALU, result register C and a status register. It generalises the fixed 16-bit/8-register datapath in word width and register count. It also adds asynchronous reset, an immediate operand path, a four-way write-back mux, and a full N/V/Z status register. Control signals are driven cycle by cycle by an external controller FSM, which is not part of this block.

---
 rtl/datapath_gen.sv | 120 ++++++++++++
 tb/tb_datapath_gen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_gen.sv
// Parametrised CPU datapath: register file, A/B operands, shifter, ALU, result C and N/V/Z status.
// All control comes cycle by cycle from an external controller; no bypassing anywhere.
module datapath_gen #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NREGS = 8,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    readnum,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [1:0]       vsel,
  input  logic             loada,
  input  logic             loadb,
  input  logic             asel,
  input  logic             bsel,
  input  logic [1:0]       shift,
  input  logic [1:0]       ALUop,
  input  logic             loadc,
  input  logic             loads,
  input  logic [WIDTH-1:0] datapath_in,
  input  logic [WIDTH-1:0] imm,
  output logic [WIDTH-1:0] datapath_out,
  output logic             Z_out,
  output logic             N_out,
  output logic             V_out
);

  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic             n_q, v_q, z_q;

  logic [WIDTH-1:0] rd_data, wb_data, b_sh, ain, bin, alu_res;
  logic             alu_v;

  assign rd_data = regs_q[readnum];

  always_comb begin
    wb_data = '0;
    unique case (vsel)
      2'b00: wb_data = c_q;
      2'b01: wb_data = datapath_in;
      2'b10: wb_data = imm;
      2'b11: wb_data = {{(WIDTH-3){1'b0}}, n_q, v_q, z_q};
      default: wb_data = '0;
    endcase
  end

  always_comb begin
    b_sh = b_q;
    unique case (shift)
      2'b00: b_sh = b_q;
      2'b01: b_sh = {b_q[MSB-1:0], 1'b0};
      2'b10: b_sh = {1'b0, b_q[MSB:1]};
      2'b11: b_sh = {b_q[MSB], b_q[MSB:1]};
      default: b_sh = b_q;
    endcase
  end

  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? imm : b_sh;

  // Overflow: sign of result disagrees with Ain when the effective operand signs agree.
  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    unique case (ALUop)
      2'b00: begin
        alu_res = ain + bin;
        alu_v   = (ain[MSB] == bin[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      2'b01: begin
        alu_res = ain - bin;
        alu_v   = (ain[MSB] != bin[MSB]) && (alu_res[MSB] != ain[MSB]);
      end
      2'b10: alu_res = ain & bin;
      2'b11: alu_res = ~bin;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write) begin
      regs_q[writenum] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      n_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      if (loada) a_q <= rd_data;
      if (loadb) b_q <= rd_data;
      if (loadc) c_q <= alu_res;
      if (loads) begin
        n_q <= alu_res[MSB];
        v_q <= alu_v;
        z_q <= (alu_res == '0);
      end
    end
  end

  assign datapath_out = c_q;
  assign Z_out        = z_q;
  assign N_out        = n_q;
  assign V_out        = v_q;

endmodule

// File: tb/tb_datapath_gen.sv
// Directed bench for datapath_gen: 16-bit/8-reg and 8-bit/4-reg instances on shared control,
// expected C/flags pushed to a scoreboard queue and checked by a separate monitor.
module tb_datapath_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, asel, bsel, loadc, loads;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] din16, imm16, dout16;
  logic [7:0]  din8, imm8, dout8;
  logic        z16, n16, v16, z8, n8, v8;

  always #5 clk = ~clk;

  datapath_gen #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(aluop), .loadc(loadc), .loads(loads), .datapath_in(din16), .imm(imm16),
    .datapath_out(dout16), .Z_out(z16), .N_out(n16), .V_out(v16)
  );

  datapath_gen #(.WIDTH(8), .NREGS(4)) dut8 (
    .clk(clk), .reset(reset), .readnum(readnum[1:0]), .writenum(writenum[1:0]), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(aluop), .loadc(loadc), .loads(loads), .datapath_in(din8), .imm(imm8),
    .datapath_out(dout8), .Z_out(z8), .N_out(n8), .V_out(v8)
  );

  typedef struct {
    logic        is8;
    logic [15:0] data;
    logic        chkf;
    logic [2:0]  nvz;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input logic is8, input logic [15:0] d, input logic chkf,
                      input logic n, input logic v, input logic z, input string nm);
    exp_t e;
    e.is8 = is8; e.data = d; e.chkf = chkf; e.nvz = {n, v, z}; e.name = nm;
    sb_q.push_back(e);
  endtask

  // Monitor: C and flags are always presented, so drain pending expectations each falling edge.
  initial begin
    exp_t        me;
    logic [15:0] act_d;
    logic [2:0]  act_f;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0) begin
        me    = sb_q.pop_front();
        act_d = me.is8 ? {8'h00, dout8} : dout16;
        act_f = me.is8 ? {n8, v8, z8} : {n16, v16, z16};
        n_cmp++;
        if (act_d !== me.data || (me.chkf && act_f !== me.nvz)) begin
          n_err++;
          $display("FAIL %s: got C=%h NVZ=%b, expected C=%h NVZ=%b", me.name, act_d, act_f,
                   me.data, me.nvz);
        end
      end
    end
  end

  task automatic clr();
    write = 1'b0; loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr_imm(input logic [2:0] idx, input logic [15:0] val);
    writenum = idx; vsel = 2'b10; imm16 = val; write = 1'b1;
    step();
  endtask

  task automatic wr_imm8(input logic [2:0] idx, input logic [7:0] val);
    writenum = idx; vsel = 2'b10; imm8 = val; write = 1'b1;
    step();
  endtask

  task automatic wr_in(input logic [2:0] idx, input logic [15:0] val);
    writenum = idx; vsel = 2'b01; din16 = val; write = 1'b1;
    step();
  endtask

  task automatic load_a(input logic [2:0] idx);
    readnum = idx; loada = 1'b1;
    step();
  endtask

  task automatic load_b(input logic [2:0] idx);
    readnum = idx; loadb = 1'b1;
    step();
  endtask

  task automatic alu(input logic as, input logic bs, input logic [1:0] sh, input logic [1:0] op,
                     input logic lc, input logic ls);
    asel = as; bsel = bs; shift = sh; aluop = op; loadc = lc; loads = ls;
    step();
  endtask

  initial begin
    reset = 1'b1;
    clr();
    readnum = '0; writenum = '0; vsel = '0; asel = 0; bsel = 0; shift = '0; aluop = '0;
    din16 = '0; imm16 = '0; din8 = '0; imm8 = '0;
    push(0, 16'h0000, 1, 0, 0, 0, "reset_state");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      load_a(3'(i));
      alu(0, 0, 2'b00, 2'b00, 1, 0);
      push(0, 16'h0000, 1, 0, 0, 0, $sformatf("t1_r%0d_zero", i));
    end

    wr_in(0, 16'h0007);
    wr_in(1, 16'h0002);
    load_a(1);
    load_b(0);
    alu(0, 0, 2'b01, 2'b00, 1, 1);
    push(0, 16'h0010, 1, 0, 0, 0, "t2_add_shl");

    wr_imm(2, 16'h7FFF);
    wr_imm(3, 16'h0001);
    load_a(2);
    load_b(3);
    alu(0, 0, 2'b00, 2'b00, 1, 1);
    push(0, 16'h8000, 1, 1, 1, 0, "t3_add_ovf");
    writenum = 3'd5; vsel = 2'b00; write = 1'b1;
    step();
    load_a(5);
    alu(0, 0, 2'b00, 2'b01, 1, 1);
    push(0, 16'h7FFF, 1, 0, 1, 0, "t3_sub_ovf");

    // Same-edge write and read of R7: A must capture the old (zero) value.
    writenum = 3'd7; vsel = 2'b10; imm16 = 16'h1234; write = 1'b1;
    readnum = 3'd7; loada = 1'b1;
    step();
    imm16 = 16'h0000;
    alu(0, 1, 2'b00, 2'b00, 1, 0);
    push(0, 16'h0000, 1, 0, 1, 0, "rdw_old_value");
    load_a(7);
    alu(0, 1, 2'b00, 2'b00, 1, 0);
    push(0, 16'h1234, 1, 0, 1, 0, "rdw_new_value");

    wr_imm(4, 16'hAAAA);
    readnum = 3'd4; loada = 1'b1; loadb = 1'b1;
    step();
    alu(0, 0, 2'b10, 2'b10, 1, 1);
    push(0, 16'h0000, 1, 0, 0, 1, "t4_and_lsr_zero");
    writenum = 3'd4; vsel = 2'b11; write = 1'b1;
    step();
    imm16 = 16'h0000;
    load_a(4);
    alu(0, 1, 2'b00, 2'b00, 1, 0);
    push(0, 16'h0001, 1, 0, 0, 1, "t4_status_word");

    wr_imm(6, 16'h8000);
    load_b(6);
    alu(0, 0, 2'b11, 2'b11, 1, 1);
    push(0, 16'h3FFF, 1, 0, 0, 0, "t5_not_asr");

    @(posedge clk); #2;
    reset = 1'b1;
    writenum = 3'd1; vsel = 2'b10; imm16 = 16'hBEEF; write = 1'b1;
    push(0, 16'h0000, 1, 0, 0, 0, "t5_async_reset");
    @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    clr();
    imm16 = 16'h0000;
    load_a(1);
    alu(0, 1, 2'b00, 2'b00, 1, 0);
    push(0, 16'h0000, 1, 0, 0, 0, "t5_write_in_reset");

    wr_imm8(0, 8'hFF);
    wr_imm8(1, 8'h01);
    load_a(0);
    load_b(1);
    alu(0, 0, 2'b00, 2'b00, 1, 1);
    push(1, 16'h0000, 1, 0, 0, 1, "t6_w8_add_wrap");
    wr_imm8(2, 8'h80);
    load_a(2);
    alu(0, 0, 2'b00, 2'b01, 1, 1);
    push(1, 16'h007F, 1, 0, 1, 0, "t6_w8_sub_ovf");
    wr_imm8(3, 8'h5A);
    load_a(3);
    imm8 = 8'h00;
    alu(0, 1, 2'b00, 2'b00, 1, 0);
    push(1, 16'h005A, 1, 0, 1, 0, "t6_w8_reg3");

    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
